// File: rtl/prime_pkg.sv
// Shared types and constants for the prime stream generator.
package prime_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TEST,
    S_EMIT,
    S_DONE
  } prime_state_t;

  // Smallest prime; also the starting candidate and the starting trial divisor.
  localparam int unsigned FIRST_PRIME = 2;

endpackage

// File: rtl/prime_div_step.sv
// One trial-division step: reports whether div has passed sqrt(cand)
// and whether div divides cand exactly. Purely combinational.
module prime_div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] cand_i,
  input  logic [W-1:0] div_i,
  output logic         is_bound_o,
  output logic         is_div_o
);

  logic [2*W-1:0] div_sq;
  logic [2*W-1:0] cand_ext;
  logic [W-1:0]   rem;

  // The square is formed at double width so it cannot overflow for any div.
  assign div_sq     = {{W{1'b0}}, div_i} * {{W{1'b0}}, div_i};
  assign cand_ext   = {{W{1'b0}}, cand_i};
  assign is_bound_o = div_sq > cand_ext;

  // div is never zero in operation; the guard keeps the remainder defined anyway.
  assign rem      = (div_i != '0) ? (cand_i % div_i) : cand_i;
  assign is_div_o = (div_i != '0) && (rem == '0);

endmodule

// File: rtl/prime_stream_gen.sv
// Enumerates every prime 2 <= p <= limit in ascending order on a
// valid/ready stream, testing one trial divisor per clock.
module prime_stream_gen
  import prime_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     limit,
  output logic [W-1:0]     prime_out,
  output logic             prime_valid,
  input  logic             prime_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  localparam logic [W-1:0]     FIRST_W = W'(FIRST_PRIME);
  localparam logic [W-1:0]     ONE_W   = W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  prime_state_t     state_q, state_d;
  logic [W-1:0]     lim_q, lim_d;
  logic [W-1:0]     cand_q, cand_d;
  logic [W-1:0]     div_q, div_d;
  logic [W-1:0]     prime_q, prime_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic is_bound;
  logic is_div;
  logic at_lim;

  prime_div_step #(.W(W)) u_div_step (
    .cand_i     (cand_q),
    .div_i      (div_q),
    .is_bound_o (is_bound),
    .is_div_o   (is_div)
  );

  // Checking against lim before any increment is what keeps limit = 2^W-1 from wrapping.
  assign at_lim = (cand_q == lim_q);

  // Next-state and next-output logic for the enumeration FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d = state_q;
    lim_d   = lim_q;
    cand_d  = cand_q;
    div_d   = div_q;
    prime_d = prime_q;
    count_d = count_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lim_d   = limit;
          count_d = '0;
          busy_d  = 1'b1;
          if (limit < FIRST_W) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            cand_d  = FIRST_W;
            div_d   = FIRST_W;
            state_d = S_TEST;
          end
        end
      end

      S_TEST: begin
        if (is_bound) begin
          prime_d = cand_q;
          valid_d = 1'b1;
          state_d = S_EMIT;
        end else if (is_div) begin
          if (at_lim) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            cand_d = cand_q + ONE_W;
            div_d  = FIRST_W;
          end
        end else begin
          div_d = div_q + ONE_W;
        end
      end

      S_EMIT: begin
        if (prime_ready) begin
          valid_d = 1'b0;
          count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
          if (at_lim) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            cand_d  = cand_q + ONE_W;
            div_d   = FIRST_W;
            state_d = S_TEST;
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= S_IDLE;
      lim_q   <= '0;
      cand_q  <= '0;
      div_q   <= '0;
      prime_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      cand_q  <= cand_d;
      div_q   <= div_d;
      prime_q <= prime_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign prime_out   = prime_q;
  assign prime_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign count       = count_q;

endmodule
